ysyx_22040000_mem_arb: RTL and testbench

YSYX_22040000_MEM_ARB -- requirements
Module: ysyx_22040000_mem_arb

---
 rtl/ysyx_22040000_mem_arb_pkg.sv | 14 +
 rtl/ysyx_22040000_rr_arb2.sv | 22 ++
 rtl/ysyx_22040000_mem_arb.sv | 152 +++++++++++++++
 tb/tb_ysyx_22040000_mem_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040000_mem_arb_pkg.sv
// rtl/ysyx_22040000_mem_arb_pkg.sv - shared types for the two-requester memory arbiter
package ysyx_22040000_mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   typedef logic req_idx_t;

   localparam req_idx_t REQ_M0 = 1'b0;
   localparam req_idx_t REQ_M1 = 1'b1;

endpackage

// File: rtl/ysyx_22040000_rr_arb2.sv
// rtl/ysyx_22040000_rr_arb2.sv - combinational 2-way round-robin grant
module ysyx_22040000_rr_arb2
   import ysyx_22040000_mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  req_idx_t   lrg,
   output logic       grant_valid,
   output req_idx_t   grant
);

   always_comb begin
      grant_valid = |valid;
      grant       = REQ_M0;
      // On a tie the requester that did not win last time goes first.
      if (&valid) begin
         grant = ~lrg;
      end else if (valid[1]) begin
         grant = REQ_M1;
      end
   end

endmodule

// File: rtl/ysyx_22040000_mem_arb.sv
// rtl/ysyx_22040000_mem_arb.sv - two-requester arbiter onto an async-read, byte-enabled memory
// Optional accept counters under YSYX_22040000_MEM_ARB_PERF_EN.
module ysyx_22040000_mem_arb
   import ysyx_22040000_mem_arb_pkg::*;
#(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 32
)
(
   input  logic                clk,
   input  logic                rst,

   input  logic                m0_req_valid,
   output logic                m0_req_ready,
   input  logic                m0_req_we,
   input  logic [AWIDTH-1:0]   m0_req_addr,
   input  logic [DWIDTH-1:0]   m0_req_wdata,
   input  logic [DWIDTH/8-1:0] m0_req_wstrb,
   output logic                m0_rsp_valid,
   input  logic                m0_rsp_ready,
   output logic [DWIDTH-1:0]   m0_rsp_rdata,

   input  logic                m1_req_valid,
   output logic                m1_req_ready,
   input  logic                m1_req_we,
   input  logic [AWIDTH-1:0]   m1_req_addr,
   input  logic [DWIDTH-1:0]   m1_req_wdata,
   input  logic [DWIDTH/8-1:0] m1_req_wstrb,
   output logic                m1_rsp_valid,
   input  logic                m1_rsp_ready,
   output logic [DWIDTH-1:0]   m1_rsp_rdata,

   output logic [DWIDTH/8-1:0] mem_wbe,
   output logic [AWIDTH-1:0]   mem_raddr,
   output logic [AWIDTH-1:0]   mem_waddr,
   output logic [DWIDTH-1:0]   mem_wdata,
   input  logic [DWIDTH-1:0]   mem_rdata
`ifdef YSYX_22040000_MEM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_grant0,
   output logic [31:0]         perf_grant1
`endif
);

   localparam int SWIDTH = DWIDTH / 8;

   state_t              state_q, state_d;
   req_idx_t            own_q, own_d;
   req_idx_t            lrg_q, lrg_d;
   logic [DWIDTH-1:0]   rdata_q;
   logic [AWIDTH-1:0]   addr_q;
   logic [DWIDTH-1:0]   wdata_q;

   logic                grant_valid;
   req_idx_t            grant;
   logic                rsp_hs;
   logic                accept_slot;
   logic                accept;

   logic                g_we;
   logic [AWIDTH-1:0]   g_addr;
   logic [DWIDTH-1:0]   g_wdata;
   logic [SWIDTH-1:0]   g_wstrb;

   ysyx_22040000_rr_arb2 u_rr_arb2 (
      .valid       ({m1_req_valid, m0_req_valid}),
      .lrg         (lrg_q),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign g_we    = (grant == REQ_M1) ? m1_req_we    : m0_req_we;
   assign g_addr  = (grant == REQ_M1) ? m1_req_addr  : m0_req_addr;
   assign g_wdata = (grant == REQ_M1) ? m1_req_wdata : m0_req_wdata;
   assign g_wstrb = (grant == REQ_M1) ? m1_req_wstrb : m0_req_wstrb;

   // A pending response frees the slot in the same cycle it is taken.
   assign rsp_hs      = (state_q == RESP) && ((own_q == REQ_M1) ? m1_rsp_ready : m0_rsp_ready);
   assign accept_slot = (state_q == IDLE) || rsp_hs;
   assign accept      = accept_slot && grant_valid && !rst;

   assign m0_rsp_valid = (state_q == RESP) && (own_q == REQ_M0);
   assign m1_rsp_valid = (state_q == RESP) && (own_q == REQ_M1);
   assign m0_rsp_rdata = rdata_q;
   assign m1_rsp_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         own_q   <= REQ_M0;
         lrg_q   <= REQ_M1;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         lrg_q   <= lrg_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      own_d        = own_q;
      lrg_d        = lrg_q;
      m0_req_ready = 1'b0;
      m1_req_ready = 1'b0;
      mem_raddr    = addr_q;
      mem_waddr    = addr_q;
      mem_wdata    = wdata_q;
      mem_wbe      = '0;
      if (accept) begin
         m0_req_ready = (grant == REQ_M0);
         m1_req_ready = (grant == REQ_M1);
         mem_raddr    = g_addr;
         mem_waddr    = g_addr;
         mem_wdata    = g_wdata;
         mem_wbe      = g_we ? g_wstrb : '0;
         state_d      = RESP;
         own_d        = grant;
         lrg_d        = grant;
      end else if (rsp_hs) begin
         state_d      = IDLE;
      end
   end

   // Writes answer with zero so a stale read value never leaks to the writer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         rdata_q <= g_we ? '0 : mem_rdata;
         addr_q  <= g_addr;
         wdata_q <= g_wdata;
      end
   end

`ifdef YSYX_22040000_MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant0 <= '0;
         perf_grant1 <= '0;
      end else if (accept) begin
         if (grant == REQ_M0) begin
            perf_grant0 <= perf_grant0 + 32'd1;
         end else begin
            perf_grant1 <= perf_grant1 + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ysyx_22040000_mem_arb.sv
// tb/tb_ysyx_22040000_mem_arb.sv - directed self-checking bench for the memory arbiter
module tb_ysyx_22040000_mem_arb;

   localparam int AWIDTH = 10;
   localparam int DWIDTH = 32;

   logic                clk;
   logic                rst;
   logic                m0_req_valid, m0_req_ready, m0_req_we;
   logic [AWIDTH-1:0]   m0_req_addr;
   logic [DWIDTH-1:0]   m0_req_wdata;
   logic [3:0]          m0_req_wstrb;
   logic                m0_rsp_valid, m0_rsp_ready;
   logic [DWIDTH-1:0]   m0_rsp_rdata;
   logic                m1_req_valid, m1_req_ready, m1_req_we;
   logic [AWIDTH-1:0]   m1_req_addr;
   logic [DWIDTH-1:0]   m1_req_wdata;
   logic [3:0]          m1_req_wstrb;
   logic                m1_rsp_valid, m1_rsp_ready;
   logic [DWIDTH-1:0]   m1_rsp_rdata;
   logic [3:0]          mem_wbe;
   logic [AWIDTH-1:0]   mem_raddr, mem_waddr;
   logic [DWIDTH-1:0]   mem_wdata, mem_rdata;
`ifdef YSYX_22040000_MEM_ARB_PERF_EN
   logic [31:0]         perf_grant0, perf_grant1;
`endif

   logic [DWIDTH-1:0]   mem [0:(1<<AWIDTH)-1];
   int                  n_checks;
   int                  n_errors;

   ysyx_22040000_mem_arb #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .m0_req_valid (m0_req_valid),
      .m0_req_ready (m0_req_ready),
      .m0_req_we    (m0_req_we),
      .m0_req_addr  (m0_req_addr),
      .m0_req_wdata (m0_req_wdata),
      .m0_req_wstrb (m0_req_wstrb),
      .m0_rsp_valid (m0_rsp_valid),
      .m0_rsp_ready (m0_rsp_ready),
      .m0_rsp_rdata (m0_rsp_rdata),
      .m1_req_valid (m1_req_valid),
      .m1_req_ready (m1_req_ready),
      .m1_req_we    (m1_req_we),
      .m1_req_addr  (m1_req_addr),
      .m1_req_wdata (m1_req_wdata),
      .m1_req_wstrb (m1_req_wstrb),
      .m1_rsp_valid (m1_rsp_valid),
      .m1_rsp_ready (m1_rsp_ready),
      .m1_rsp_rdata (m1_rsp_rdata),
      .mem_wbe      (mem_wbe),
      .mem_raddr    (mem_raddr),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
`ifdef YSYX_22040000_MEM_ARB_PERF_EN
      ,
      .perf_grant0  (perf_grant0),
      .perf_grant1  (perf_grant1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_raddr];

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m0(input logic v, input logic we, input logic [AWIDTH-1:0] a,
                           input logic [DWIDTH-1:0] d, input logic [3:0] s);
      m0_req_valid = v; m0_req_we = we; m0_req_addr = a; m0_req_wdata = d; m0_req_wstrb = s;
   endtask

   task automatic drive_m1(input logic v, input logic we, input logic [AWIDTH-1:0] a,
                           input logic [DWIDTH-1:0] d, input logic [3:0] s);
      m1_req_valid = v; m1_req_we = we; m1_req_addr = a; m1_req_wdata = d; m1_req_wstrb = s;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = '0;
      mem[5] = 32'hDEADBEEF;
      rst = 1'b1;
      m0_rsp_ready = 1'b1;
      m1_rsp_ready = 1'b1;
      drive_m0(0, 0, '0, '0, '0);
      drive_m1(0, 0, '0, '0, '0);
      tick();

      // Write offered while reset is held must not reach memory.
      drive_m0(1, 1, 10'h030, 32'hFFFFFFFF, 4'hF);
      @(negedge clk);
      check("rst_wbe", mem_wbe, 0);
      check("rst_m0_ready", m0_req_ready, 0);
      tick();
      rst = 1'b0;
      drive_m0(0, 0, '0, '0, '0);
      @(negedge clk);
      check("reset_m0_rsp_valid", m0_rsp_valid, 0);
      check("reset_m1_rsp_valid", m1_rsp_valid, 0);
      check("reset_wbe", mem_wbe, 0);
      tick();

      // m0 read of 0x005
      drive_m0(1, 0, 10'h005, 32'h0, 4'hF);
      @(negedge clk);
      check("rd_m0_ready", m0_req_ready, 1);
      check("rd_m1_ready", m1_req_ready, 0);
      check("rd_raddr", mem_raddr, 10'h005);
      check("rd_wbe", mem_wbe, 0);
      tick();
      drive_m0(0, 0, '0, '0, '0);
      @(negedge clk);
      check("rd_rsp_valid", m0_rsp_valid, 1);
      check("rd_rsp_m1_valid", m1_rsp_valid, 0);
      check("rd_rdata", m0_rsp_rdata, 32'hDEADBEEF);
      tick();

      // m1 partial write, then read back
      drive_m1(1, 1, 10'h010, 32'h11223344, 4'b0011);
      @(negedge clk);
      check("wr_m1_ready", m1_req_ready, 1);
      check("wr_wbe", mem_wbe, 4'b0011);
      check("wr_waddr", mem_waddr, 10'h010);
      check("wr_wdata", mem_wdata, 32'h11223344);
      tick();
      drive_m1(0, 0, '0, '0, '0);
      @(negedge clk);
      check("wr_wbe_one_cycle", mem_wbe, 0);
      check("wr_rsp_valid", m1_rsp_valid, 1);
      check("wr_rsp_zero", m1_rsp_rdata, 0);
      tick();
      drive_m1(1, 0, 10'h010, 32'h0, 4'hF);
      @(negedge clk);
      check("rb_m1_ready", m1_req_ready, 1);
      check("rb_wbe", mem_wbe, 0);
      tick();
      drive_m1(0, 0, '0, '0, '0);
      @(negedge clk);
      check("rb_rdata", m1_rsp_rdata, 32'h00003344);
      tick();

      // Both requesting: last grant was m1, so m0 leads and they alternate
      drive_m0(1, 0, 10'h005, 32'h0, 4'h0);
      drive_m1(1, 0, 10'h010, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("rr_m0_ready_%0d", i), m0_req_ready, (i % 2 == 0));
         check($sformatf("rr_m1_ready_%0d", i), m1_req_ready, (i % 2 == 1));
         if (i > 0) begin
            check($sformatf("rr_rsp0_%0d", i), m0_rsp_valid, (i % 2 == 1));
            check($sformatf("rr_rsp1_%0d", i), m1_rsp_valid, (i % 2 == 0));
            check($sformatf("rr_rdata_%0d", i), m0_rsp_rdata,
                  (i % 2 == 1) ? 32'hDEADBEEF : 32'h00003344);
         end
         tick();
      end
      drive_m0(0, 0, '0, '0, '0);
      drive_m1(0, 0, '0, '0, '0);
      @(negedge clk);
      check("rr_last_rsp1", m1_rsp_valid, 1);
      check("rr_last_rdata", m1_rsp_rdata, 32'h00003344);
      tick();

      // m0 stalls its response; m1 must wait, non-owner rsp_ready ignored
      m0_rsp_ready = 1'b0;
      drive_m0(1, 0, 10'h005, 32'h0, 4'h0);
      @(negedge clk);
      check("bp_m0_ready", m0_req_ready, 1);
      tick();
      drive_m0(0, 0, '0, '0, '0);
      drive_m1(1, 0, 10'h010, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("bp_m1_wait_%0d", i), m1_req_ready, 0);
         check($sformatf("bp_rsp_hold_%0d", i), m0_rsp_valid, 1);
         check($sformatf("bp_rdata_hold_%0d", i), m0_rsp_rdata, 32'hDEADBEEF);
         tick();
      end
      m0_rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_m1_same_cycle", m1_req_ready, 1);
      tick();
      drive_m1(0, 0, '0, '0, '0);
      m1_rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_m1_rsp", m1_rsp_valid, 1);
      check("bp_m0_rsp_gone", m0_rsp_valid, 0);
      check("bp_m1_rdata", m1_rsp_rdata, 32'h00003344);
      tick();

      // Reset in RESP drops the response; a write offered during reset is lost
      rst = 1'b1;
      m1_rsp_ready = 1'b1;
      drive_m0(1, 1, 10'h020, 32'hA5A5A5A5, 4'hF);
      @(negedge clk);
      check("rstr_wbe", mem_wbe, 0);
      check("rstr_m0_ready", m0_req_ready, 0);
      tick();
      rst = 1'b0;
      drive_m0(1, 0, 10'h020, 32'h0, 4'h0);
      drive_m1(1, 0, 10'h010, 32'h0, 4'h0);
      @(negedge clk);
      check("rstr_rsp0", m0_rsp_valid, 0);
      check("rstr_rsp1", m1_rsp_valid, 0);
      check("rstr_tie_m0", m0_req_ready, 1);
      check("rstr_tie_m1", m1_req_ready, 0);
      tick();
      drive_m0(0, 0, '0, '0, '0);
      drive_m1(0, 0, '0, '0, '0);
      @(negedge clk);
      check("rstr_rsp_m0", m0_rsp_valid, 1);
      check("rstr_no_write", m0_rsp_rdata, 0);
      tick();

`ifdef YSYX_22040000_MEM_ARB_PERF_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_m0(1, 0, 10'h005, 32'h0, 4'h0);
      drive_m1(1, 0, 10'h010, 32'h0, 4'h0);
      for (int i = 0; i < 10; i++) tick();
      drive_m1(0, 0, '0, '0, '0);
      for (int i = 0; i < 2; i++) tick();
      drive_m0(0, 0, '0, '0, '0);
      tick();
      @(negedge clk);
      check("perf0", perf_grant0, 7);
      check("perf1", perf_grant1, 5);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("perf0_rst", perf_grant0, 0);
      check("perf1_rst", perf_grant1, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
